// File: rtl/seq_multiplier_hs.sv
// seq_multiplier_hs
//   Iterative shift-add multiplier with valid/ready handshake on both sides.
//   Computes o_result = i_mult1 * i_mult2. The i_signed flag selects
//   two's-complement or unsigned interpretation for both operands.
//   K multiplier bits are retired per cycle, so a product takes M/K CALC
//   cycles. The result is held in DONE until the consumer takes it.
//
//   Ports
//     i_clk, i_rst    clock / synchronous active-high reset
//     i_in_valid      operand beat valid
//     o_in_ready      block can accept an operand beat (state IDLE)
//     i_signed        1: operands two's complement, 0: unsigned
//     i_mult1 [N]     multiplicand
//     i_mult2 [M]     multiplier
//     o_result [N+M]  product, valid while o_out_valid
//     o_out_valid     completed product available (state DONE)
//     i_out_ready     consumer accepts the product
//     o_busy          high in CALC or DONE

// One partial-product lane: multiplier bit SH of the current group selects
// the multiplicand shifted by SH. The TOP lane handles the sign bit. On the
// final signed iteration it carries weight -2^(M-1), so it is negated.
module seq_multiplier_hs_lane #(
  parameter int W   = 16,
  parameter int SH  = 0,
  parameter bit TOP = 1'b0
) (
  input  logic [W-1:0] mcand_i,
  input  logic         bit_i,
  input  logic         neg_i,
  output logic [W-1:0] pp_o
);
  logic [W-1:0] shifted;
  logic         do_neg;

  assign shifted = mcand_i << SH;
  assign do_neg  = TOP & neg_i;

  always_comb begin
    pp_o = '0;
    if (bit_i) pp_o = do_neg ? (~shifted + W'(1)) : shifted;
  end
endmodule

module seq_multiplier_hs #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int K = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic           i_signed,
  input  logic [N-1:0]   i_mult1,
  input  logic [M-1:0]   i_mult2,
  output logic [N+M-1:0] o_result,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic           o_busy
);
  localparam int W     = N + M;
  localparam int ITERS = M / K;
  localparam int CW    = $clog2(ITERS) + 1;

  generate
    if ((M % K) != 0) begin : g_bad_k
      $error("seq_multiplier_hs: M must be a multiple of K");
    end
    if (N < 2 || M < 2) begin : g_bad_w
      $error("seq_multiplier_hs: N and M must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mcand_q;   // extended multiplicand, shifted left K per cycle
  logic [M-1:0]    mplier_q;  // remaining multiplier bits, LSB group in [K-1:0]
  logic            sgn_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    result_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            last;
  logic [K-1:0][W-1:0] pp;
  logic [W-1:0]    sum;

  assign accept = i_in_valid & o_in_ready;
  assign last   = (cnt_q == CW'(ITERS - 1));

  // The highest lane sees multiplier bit M-1 on the final iteration.
  generate
    for (genvar j = 0; j < K; j++) begin : g_lane
      seq_multiplier_hs_lane #(
        .W  (W),
        .SH (j),
        .TOP(j == K - 1)
      ) u_lane (
        .mcand_i(mcand_q),
        .bit_i  (mplier_q[j]),
        .neg_i  (sgn_q & last),
        .pp_o   (pp[j])
      );
    end
  endgenerate

  always_comb begin
    sum = acc_q;
    for (int j = 0; j < K; j++) sum = sum + pp[j];
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = CALC;
      CALC:    if (last)        state_d = DONE;
      DONE:    if (i_out_ready) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // FSM: outputs decode from state only
  always_comb begin
    o_in_ready  = (state_q == IDLE);
    o_out_valid = (state_q == DONE);
    o_busy      = (state_q != IDLE);
  end

  // Datapath. Operands are only sampled on accept, so input activity
  // outside IDLE has no effect. result_q is kept after the handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      sgn_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          mcand_q  <= {{M{i_mult1[N-1] & i_signed}}, i_mult1};
          mplier_q <= i_mult2;
          sgn_q    <= i_signed;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        CALC: begin
          acc_q    <= sum;
          mcand_q  <= mcand_q << K;
          mplier_q <= mplier_q >> K;
          cnt_q    <= cnt_q + CW'(1);
          if (last) result_q <= sum;
        end
        default: ;
      endcase
    end
  end

  assign o_result = result_q;
endmodule

// File: tb/tb_seq_multiplier_hs.sv
// Directed bench for seq_multiplier_hs. Three instances (K=1,2,4) share
// the operand/handshake stimulus. Each exposes its own outputs at index
// 0/1/2 of the packed output vectors.
module tb_seq_multiplier_hs;
  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            sgn;
  logic [7:0]      mult1, mult2;
  logic            out_ready;
  logic [2:0]      ir, ov, bz;
  logic [2:0][15:0] res;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_multiplier_hs #(.N(8), .M(8), .K(1)) u_k1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(ir[0]),
    .i_signed(sgn), .i_mult1(mult1), .i_mult2(mult2), .o_result(res[0]),
    .o_out_valid(ov[0]), .i_out_ready(out_ready), .o_busy(bz[0]));
  seq_multiplier_hs #(.N(8), .M(8), .K(2)) u_k2 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(ir[1]),
    .i_signed(sgn), .i_mult1(mult1), .i_mult2(mult2), .o_result(res[1]),
    .o_out_valid(ov[1]), .i_out_ready(out_ready), .o_busy(bz[1]));
  seq_multiplier_hs #(.N(8), .M(8), .K(4)) u_k4 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(ir[2]),
    .i_signed(sgn), .i_mult1(mult1), .i_mult2(mult2), .o_result(res[2]),
    .o_out_valid(ov[2]), .i_out_ready(out_ready), .o_busy(bz[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 4 : 2;
  endfunction

  // Reference product by ordinary arithmetic on extended operands.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb;
    logic [15:0] p;
    if (s) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      p  = 16'(sa * sb);
    end else begin
      p  = 16'({8'd0, a} * {8'd0, b});
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on all three instances with i_out_ready=1.
  // Each instance shows o_out_valid for exactly one cycle, after edge t+M/K.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s,
                    input logic [15:0] exp, input string tag);
    mult1 = a; mult2 = b; sgn = s; out_ready = 1'b1; in_valid = 1'b1;
    check({tag, " in_ready"}, {29'd0, ir}, 32'h7);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        check($sformatf("%s k%0d valid c%0d", tag, d, c), {31'd0, ov[d]},
              {31'd0, c == lat_of(d)});
        if (c == lat_of(d)) check($sformatf("%s k%0d result", tag, d), {16'd0, res[d]}, {16'd0, exp});
      end
    end
    tick();
    check({tag, " idle in_ready"}, {29'd0, ir}, 32'h7);
    check({tag, " idle valid"}, {29'd0, ov}, 32'h0);
    check({tag, " kept result"}, {16'd0, res[0]}, {16'd0, exp});
  endtask

  initial begin
    logic [7:0] sa [50];
    logic [7:0] sb [50];
    logic       ss [50];
    int         bc, nv;

    rst = 1'b1; in_valid = 1'b0; sgn = 1'b0; mult1 = '0; mult2 = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst in_ready", {29'd0, ir}, 32'h7);
    check("rst out_valid", {29'd0, ov}, 32'h0);
    check("rst busy", {29'd0, bz}, 32'h0);
    check("rst result", {16'd0, res[0]}, 32'h0);
    rst = 1'b0;
    tick();

    op(8'd13,  8'd3,   1'b0, 16'h0027, "u13x3");
    op(8'hFF,  8'hFF,  1'b0, 16'hFE01, "u255x255");
    op(8'hFD,  8'h05,  1'b1, 16'hFFF1, "s-3x5");
    op(8'h80,  8'h80,  1'b1, 16'h4000, "s-128x-128");
    op(8'h80,  8'h7F,  1'b1, 16'hC080, "s-128x127");
    op(8'd200, 8'd100, 1'b0, 16'h4E20, "u200x100");
    op(8'hF9,  8'h09,  1'b1, 16'hFFC1, "s-7x9");

    // Backpressure: hold the product while the consumer stalls.
    mult1 = 8'h7F; mult2 = 8'h02; sgn = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    check("bp valid", {31'd0, ov[0]}, 32'h1);
    check("bp result", {16'd0, res[0]}, 32'h00FE);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; mult1 = 8'h01; mult2 = 8'h01;
      tick();
      check("bp hold valid", {31'd0, ov[0]}, 32'h1);
      check("bp hold result", {16'd0, res[0]}, 32'h00FE);
      check("bp hold in_ready", {31'd0, ir[0]}, 32'h0);
      check("bp hold busy", {31'd0, bz[0]}, 32'h1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp release valid", {31'd0, ov[0]}, 32'h0);
    check("bp release in_ready", {31'd0, ir[0]}, 32'h1);
    check("bp release result", {16'd0, res[0]}, 32'h00FE);

    // Back-to-back stream with in_valid held high (K=1 instance checked).
    // Each product keeps the block busy for M/K CALC cycles + 1 DONE cycle.
    for (int i = 0; i < 50; i++) begin
      sa[i] = 8'($urandom); sb[i] = 8'($urandom); ss[i] = 1'($urandom);
    end
    sa[0] = 8'h80; sb[0] = 8'h80; ss[0] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      mult1 = sa[i]; mult2 = sb[i]; sgn = ss[i]; in_valid = 1'b1;
      check($sformatf("stream%0d in_ready", i), {31'd0, ir[0]}, 32'h1);
      tick();
      bc = 0; nv = 0;
      while (bz[0] && bc < 20) begin
        if (ov[0]) begin
          nv++;
          check($sformatf("stream%0d result", i), {16'd0, res[0]},
                {16'd0, ref_mul(sa[i], sb[i], ss[i])});
        end
        tick();
        bc++;
      end
      check($sformatf("stream%0d busy cycles", i), bc, 32'd9);
      check($sformatf("stream%0d valid beats", i), nv, 32'd1);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) tick();

    // Reset mid-CALC abandons the operation.
    mult1 = 8'd100; mult2 = 8'd100; sgn = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst in_ready", {31'd0, ir[0]}, 32'h1);
    check("midrst valid", {31'd0, ov[0]}, 32'h0);
    check("midrst result", {16'd0, res[0]}, 32'h0);
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ov[0]) nv++;
    end
    check("midrst no valid", nv, 32'd0);
    op(8'd6, 8'd7, 1'b0, 16'h002A, "u6x7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
